// File: rtl/produto_escalar.sv
// produto_escalar: sequential signed dot product of two 8-element vectors.
// One shared multiplier, one MAC step per clock. concluido rises 8 cycles
// after the accepted start edge.
// Optional build macro PRODUTO_ESCALAR_SAT_EN: the accumulator saturates to
// the signed 2*DATA_W range instead of wrapping.
module produto_escalar #(
  parameter int DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     a0,
  input  logic [DATA_W-1:0]     a1,
  input  logic [DATA_W-1:0]     a2,
  input  logic [DATA_W-1:0]     a3,
  input  logic [DATA_W-1:0]     a4,
  input  logic [DATA_W-1:0]     a5,
  input  logic [DATA_W-1:0]     a6,
  input  logic [DATA_W-1:0]     a7,
  input  logic [DATA_W-1:0]     b0,
  input  logic [DATA_W-1:0]     b1,
  input  logic [DATA_W-1:0]     b2,
  input  logic [DATA_W-1:0]     b3,
  input  logic [DATA_W-1:0]     b4,
  input  logic [DATA_W-1:0]     b5,
  input  logic [DATA_W-1:0]     b6,
  input  logic [DATA_W-1:0]     b7,
  input  logic                  iniciar,
  output logic                  concluido,
  output logic [2*DATA_W-1:0]   resultado
);

  localparam int RW = 2 * DATA_W;

  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    CALCULANDO = 2'd1,
    CONCLUIDO  = 2'd2
  } estado_t;

  estado_t           state_q, state_d;
  logic [DATA_W-1:0] a_in [8];
  logic [DATA_W-1:0] b_in [8];
  logic [DATA_W-1:0] a_q  [8];
  logic [DATA_W-1:0] a_d  [8];
  logic [DATA_W-1:0] b_q  [8];
  logic [DATA_W-1:0] b_d  [8];
  logic [RW-1:0]     acc_q, acc_d;
  logic [RW-1:0]     res_q, res_d;
  logic [2:0]        idx_q, idx_d;
  logic              conc_q, conc_d;

  // Gather the flat operand ports into arrays indexed by element number.
  assign a_in[0] = a0;  assign b_in[0] = b0;
  assign a_in[1] = a1;  assign b_in[1] = b1;
  assign a_in[2] = a2;  assign b_in[2] = b2;
  assign a_in[3] = a3;  assign b_in[3] = b3;
  assign a_in[4] = a4;  assign b_in[4] = b4;
  assign a_in[5] = a5;  assign b_in[5] = b5;
  assign a_in[6] = a6;  assign b_in[6] = b6;
  assign a_in[7] = a7;  assign b_in[7] = b7;

  // Single shared multiplier fed only from captured operands, so there is
  // no combinational path from the operand ports to the outputs.
  logic [DATA_W-1:0]    a_sel, b_sel;
  logic signed [RW-1:0] a_ext, b_ext, prod;
  logic [RW-1:0]        mac_sum;

  assign a_sel = a_q[idx_q];
  assign b_sel = b_q[idx_q];
  assign a_ext = {{DATA_W{a_sel[DATA_W-1]}}, a_sel};
  assign b_ext = {{DATA_W{b_sel[DATA_W-1]}}, b_sel};
  // Low RW bits of the sign-extended product are the exact signed product.
  assign prod  = a_ext * b_ext;

`ifdef PRODUTO_ESCALAR_SAT_EN
  // One guard bit detects signed overflow of the running sum.
  logic [RW:0] sum_wide;
  assign sum_wide = {acc_q[RW-1], acc_q} + {prod[RW-1], prod};

  // Clamp to the most positive/negative value when the guard bit disagrees.
  always_comb begin
    mac_sum = sum_wide[RW-1:0];
    if (sum_wide[RW] != sum_wide[RW-1]) begin
      mac_sum = sum_wide[RW] ? {1'b1, {(RW-1){1'b0}}} : {1'b0, {(RW-1){1'b1}}};
    end
  end
`else
  // Plain modulo-2^RW accumulation.
  assign mac_sum = acc_q + prod;
`endif

  // Next-state and datapath update: start capture, MAC steps, completion.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    res_d   = res_q;
    conc_d  = conc_q;
    case (state_q)
      OCIOSO, CONCLUIDO: begin
        if (iniciar) begin
          a_d     = a_in;
          b_d     = b_in;
          acc_d   = '0;
          idx_d   = 3'd0;
          conc_d  = 1'b0;
          state_d = CALCULANDO;
        end
      end
      CALCULANDO: begin
        // iniciar is deliberately ignored here: no restart mid-computation.
        acc_d = mac_sum;
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          res_d   = mac_sum;
          conc_d  = 1'b1;
          state_d = CONCLUIDO;
        end
      end
      default: state_d = OCIOSO;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state_q <= OCIOSO;
    else        state_q <= state_d;
  end

  // Datapath registers; reset discards any partial computation.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
      acc_q  <= '0;
      res_q  <= '0;
      idx_q  <= 3'd0;
      conc_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      res_q  <= res_d;
      idx_q  <= idx_d;
      conc_q <= conc_d;
    end
  end

  assign concluido = conc_q;
  assign resultado = res_q;

endmodule

// File: tb/tb_produto_escalar.sv
// Testbench for produto_escalar: directed table, hand-written multi-cycle
// sequences and random vectors against a wide-integer reference model.
// Honours PRODUTO_ESCALAR_SAT_EN for expected values.
module tb_produto_escalar;

  typedef logic [7:0][31:0] vec_t;
  typedef struct {
    string       nm;
    vec_t        a;
    vec_t        b;
    logic [63:0] exp;
  } vec_rec_t;

  localparam logic signed [127:0] SMAX = 128'sd9223372036854775807;
  localparam logic signed [127:0] SMIN = -SMAX - 128'sd1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iniciar = 1'b0;
  logic [31:0] drv_a [8];
  logic [31:0] drv_b [8];
  logic        concluido;
  logic [63:0] resultado;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] prev_res = '0;
  vec_rec_t    tbl [5];

  always #5 clk = ~clk;

  produto_escalar #(.DATA_W(32)) dut (
    .clk_i(clk), .rst_n(rst_n),
    .a0(drv_a[0]), .a1(drv_a[1]), .a2(drv_a[2]), .a3(drv_a[3]),
    .a4(drv_a[4]), .a5(drv_a[5]), .a6(drv_a[6]), .a7(drv_a[7]),
    .b0(drv_b[0]), .b1(drv_b[1]), .b2(drv_b[2]), .b3(drv_b[3]),
    .b4(drv_b[4]), .b5(drv_b[5]), .b6(drv_b[6]), .b7(drv_b[7]),
    .iniciar(iniciar), .concluido(concluido), .resultado(resultado)
  );

  // Reference: exact products summed in 128-bit arithmetic, then either
  // clamped after every step or reduced modulo 2^64 at the end.
  function automatic logic [63:0] model(input vec_t va, input vec_t vb);
    logic signed [127:0] acc, pa, pb;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      pa  = $signed(va[i]);
      pb  = $signed(vb[i]);
      acc = acc + pa * pb;
`ifdef PRODUTO_ESCALAR_SAT_EN
      if (acc > SMAX) acc = SMAX;
      else if (acc < SMIN) acc = SMIN;
`endif
    end
    return acc[63:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", nm, got, exp);
    end else begin
      $display("ok   %s: %h", nm, got);
    end
  endtask

  task automatic load(input vec_t va, input vec_t vb);
    for (int i = 0; i < 8; i++) begin
      drv_a[i] = va[i];
      drv_b[i] = vb[i];
    end
  endtask

  // Wait (bounded) for concluido; optionally pulse iniciar before edge ign_at.
  task automatic wait_done(input int ign_at, input bit keep_start, output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k == ign_at) iniciar = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (!keep_start) iniciar = 1'b0;
      if (concluido) begin
        lat = k;
        break;
      end
    end
  endtask

  // Full transaction: start edge, scramble operands, wait, check.
  task automatic run(input string nm, input vec_t va, input vec_t vb,
                     input logic [63:0] exp, input int ign_at);
    int lat;
    @(negedge clk);
    load(va, vb);
    iniciar = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iniciar = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drv_a[i] = '0;
      drv_b[i] = $urandom;
    end
    chk({nm, " done_low"}, {63'd0, concluido}, 64'd0);
    chk({nm, " hold_old"}, resultado, prev_res);
    wait_done(ign_at, 1'b0, lat);
    chk({nm, " latency"}, 64'(lat), 64'd8);
    chk({nm, " result"}, resultado, exp);
    prev_res = exp;
  endtask

  function automatic vec_t rnd_vec();
    vec_t v;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 5))
        0:       v[i] = 32'h8000_0000;
        1:       v[i] = 32'h7FFF_FFFF;
        2:       v[i] = 32'($urandom_range(0, 15)) - 32'd8;
        default: v[i] = $urandom;
      endcase
    end
    return v;
  endfunction

  initial begin
    int   lat;
    vec_t va, vb, va2, vb2;
    logic [63:0] e1, e2;

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      tbl[0].a[i] = 32'(i + 1);
      tbl[0].b[i] = 32'(i + 1);
      tbl[1].a[i] = (i % 2 == 0) ? 32'(i / 2 + 1) : -32'(i / 2 + 1);
      tbl[1].b[i] = 32'(i / 2 + 1);
      tbl[2].a[i] = 32'hFFFF_FFFF;
      tbl[2].b[i] = 32'(i + 1);
      tbl[3].a[i] = 32'h8000_0000;
      tbl[3].b[i] = 32'h8000_0000;
      tbl[4].a[i] = 32'h7FFF_FFFF;
      tbl[4].b[i] = 32'h7FFF_FFFF;
    end
    tbl[0].nm = "t1_seq";  tbl[0].exp = 64'd204;
    tbl[1].nm = "t2_zero"; tbl[1].exp = 64'd0;
    tbl[2].nm = "t3_neg";  tbl[2].exp = 64'hFFFF_FFFF_FFFF_FFDC;
    tbl[3].nm = "t5_min";
    tbl[4].nm = "t5_max";
`ifdef PRODUTO_ESCALAR_SAT_EN
    tbl[3].exp = 64'h7FFF_FFFF_FFFF_FFFF;
    tbl[4].exp = 64'h7FFF_FFFF_FFFF_FFFF;
`else
    tbl[3].exp = 64'd0;
    tbl[4].exp = 64'hFFFF_FFF8_0000_0008;
`endif

    for (int i = 0; i < 8; i++) begin
      drv_a[i] = '0;
      drv_b[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("reset concluido", {63'd0, concluido}, 64'd0);
    chk("reset resultado", resultado, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 5; t++) run(tbl[t].nm, tbl[t].a, tbl[t].b, tbl[t].exp, 0);

    // Start request during CALCULANDO is ignored.
    run("t4_ignore", tbl[0].a, tbl[0].b, 64'd204, 4);

    // Asynchronous reset in the middle of a computation.
    @(negedge clk);
    load(tbl[2].a, tbl[2].b);
    iniciar = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iniciar = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t4_rst concluido", {63'd0, concluido}, 64'd0);
    chk("t4_rst resultado", resultado, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_res = '0;
    run("t4_after_rst", tbl[0].a, tbl[0].b, 64'd204, 0);

    // Back-to-back with iniciar held high.
    va = rnd_vec(); vb = rnd_vec(); va2 = rnd_vec(); vb2 = rnd_vec();
    e1 = model(va, vb);
    e2 = model(va2, vb2);
    @(negedge clk);
    load(va, vb);
    iniciar = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_done(0, 1'b1, lat);
    chk("t6 first latency", 64'(lat), 64'd8);
    chk("t6 first result", resultado, e1);
    load(va2, vb2);
    @(posedge clk);
    @(negedge clk);
    iniciar = 1'b0;
    chk("t6 restart done_low", {63'd0, concluido}, 64'd0);
    chk("t6 restart hold_old", resultado, e1);
    wait_done(0, 1'b0, lat);
    chk("t6 second latency", 64'(lat), 64'd8);
    chk("t6 second result", resultado, e2);
    prev_res = e2;

    // Random vectors against the reference model.
    for (int r = 0; r < 16; r++) begin
      va = rnd_vec();
      vb = rnd_vec();
      run($sformatf("rnd%0d", r), va, vb, model(va, vb), (r % 3 == 0) ? 3 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/produto_escalar.md
Name: produto_escalar

Overview:
Sequential signed dot-product engine for two 8-element vectors of 32-bit two's-complement integers. Computes sum(a_i*b_i) for i=0..7 over 8 multiply-accumulate cycles after a start request. Reports a 64-bit result with a completion flag. Sits as a memory-mapped accelerator core behind a SoC bus wrapper that drives the operands and iniciar and reads concluido/resultado.

Parameters:
DATA_W, 32, width of each vector element (signed); resultado width is 2*DATA_W.

Ports:
clk_i  input  1  system clock; all state changes on rising edge.
rst_n  input  1  asynchronous, active-low reset.
a0..a7  input  DATA_W each  vector A elements, signed two's complement.
b0..b7  input  DATA_W each  vector B elements, signed two's complement.
iniciar  input  1  start request, level-sampled on rising edge.
concluido  output  1  result valid/done flag.
resultado  output  2*DATA_W  signed dot product.

Behaviour:
- Reset (rst_n=0, asynchronous, active-low): state=OCIOSO; accumulator, index, resultado and concluido all cleared to 0; operand registers cleared. Reset mid-computation aborts it with no partial result retained.
- FSM states:
  - OCIOSO: idle.
  - CALCULANDO: MAC running.
  - CONCLUIDO: result held.
- Start: iniciar=1 at a rising edge while in OCIOSO or CONCLUIDO (edge E0) has these effects:
  - all 16 operands captured into internal registers;
  - accumulator cleared; index=0;
  - concluido<=0; state<=CALCULANDO.
  - Operand inputs may change after E0 without affecting the result.
- CALCULANDO: each edge E1..E8 performs acc <= acc + sext(a_i)*sext(b_i) for i=index, then index++.
  - At E8 resultado<=final sum, concluido<=1, state<=CONCLUIDO.
  - Latency: concluido rises exactly 8 clock cycles after E0.
- iniciar while in CALCULANDO is ignored; there is no restart and no abort except reset.
- CONCLUIDO: concluido stays 1 and resultado stays stable until the next accepted iniciar. On that edge concluido drops to 0; resultado keeps its old value until the new E8.
- iniciar held high continuously restarts a new computation at each edge in CONCLUIDO. That edge is the E0 of the next computation, so the back-to-back period is 9 cycles.
- Arithmetic:
  - Each product is a full 2*DATA_W-bit signed multiply.
  - Accumulation is 2*DATA_W-bit signed, wrapping modulo 2^(2*DATA_W) (without the optional feature).
  - Products of -2^31 * -2^31 are exact (2^62).
- One multiplier only; no combinational path from operand inputs to outputs.

Optional Feature:
PRODUTO_ESCALAR_SAT_EN:
- Defined: the accumulator uses one guard bit internally. Each accumulation that exceeds the signed 64-bit range clamps to 0x7FFF_FFFF_FFFF_FFFF or 0x8000_0000_0000_0000, and clamping persists as the running value.
- Undefined: plain wrap-around as above. Timing and interface are identical in both cases.

Test Plan:
1. Reset, then a=b=[1,2,3,4,5,6,7,8]; pulse iniciar 1 cycle -> concluido=1 exactly 8 cycles after start edge, resultado=204.
2. a=[1,-1,2,-2,3,-3,4,-4], b=[1,1,2,2,3,3,4,4] -> resultado=0; concluido deasserts on start edge, reasserts after 8 cycles.
3. a=all -1, b=[1..8] -> resultado=-36 (0xFFFF_FFFF_FFFF_FFDC). Change the a inputs to 0 one cycle after start -> result unchanged (operands captured).
4. Assert iniciar again during CALCULANDO cycle 4 -> ignored; result and latency unchanged. Assert rst_n=0 at cycle 5 -> concluido=0, resultado=0 immediately; the next start computes correctly.
5. All a=b=0x8000_0000 -> 8*2^62:
   - wraps to 0 without PRODUTO_ESCALAR_SAT_EN;
   - gives 0x7FFF_FFFF_FFFF_FFFF with it.
6. Hold iniciar high across completion -> new computation starts on the edge after concluido rises; concluido drops for 8 cycles, and resultado holds the old value until the new one is written.
